// File: rtl/mmio_console_bridge.sv
// mmio_console_bridge: sits on the core memory port in front of Memory.
// A 16-byte MMIO window at CONSOLE_BASE holds a console: byte writes to TXDATA
// are queued in a TX FIFO and drained to a host valid/ready byte stream.
// Accesses outside the window pass through to Memory unchanged.
//
// Ports:
//   i_clk, i_reset                   clock, asynchronous active-high reset
//   i_halt                           core halted; window writes ignored, drain continues
//   i_cpu_addr/wr_data/wr_mask/rd_mask, o_cpu_rd_data   core side
//   o_mem_addr/wr_data/wr_mask/rd_mask, i_mem_rd_data   Memory side
//   o_tx_data, o_tx_valid, i_tx_ready                   host byte stream
//
// Register map (sel = addr[3:2]):
//   0 TXDATA (W)  1 STATUS (R) {16'h0, count[7:0], 6'h0, empty, full}
//   2 DROPPED (R) rejected-push count  3 reserved (reads 0)
module mmio_console_bridge #(
  parameter logic [31:0] CONSOLE_BASE = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_halt,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wr_data,
  input  logic [1:0]  i_cpu_wr_mask,
  input  logic [2:0]  i_cpu_rd_mask,
  output logic [31:0] o_cpu_rd_data,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     dropped_q, dropped_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];

  logic        hit;
  logic [1:0]  sel;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_req;
  logic        push;
  logic [31:0] count_ext;
  logic [31:0] window_rd_data;

  assign hit   = (i_cpu_addr[31:4] == CONSOLE_BASE[31:4]);
  assign sel   = i_cpu_addr[3:2];
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(FIFO_DEPTH));

  assign o_tx_valid = ~empty;
  assign o_tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

  assign pop      = o_tx_valid & i_tx_ready;
  assign push_req = hit & (sel == 2'd0) & (i_cpu_wr_mask != 2'b00) & ~i_halt;
  // When full, a push only fits if the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  // Memory side: address/data always mirrored, strobes suppressed in the window.
  assign o_mem_addr    = i_cpu_addr;
  assign o_mem_wr_data = i_cpu_wr_data;
  assign o_mem_wr_mask = hit ? 2'b00 : i_cpu_wr_mask;
  assign o_mem_rd_mask = hit ? 3'b000 : i_cpu_rd_mask;

  assign count_ext = 32'(count_q);

  always_comb begin
    window_rd_data = 32'h0;
    unique case (sel)
      2'd1:    window_rd_data = {16'h0, count_ext[7:0], 6'h0, empty, full};
      2'd2:    window_rd_data = {16'h0, dropped_q};
      default: window_rd_data = 32'h0;
    endcase
  end

  assign o_cpu_rd_data = hit ? window_rd_data : i_mem_rd_data;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    if (push_req && !push) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= i_cpu_wr_data[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_console_bridge.sv
module tb_mmio_console_bridge;

  localparam logic [31:0] Base = 32'hFFFF_0000;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_halt;
  logic [31:0] i_cpu_addr;
  logic [31:0] i_cpu_wr_data;
  logic [1:0]  i_cpu_wr_mask;
  logic [2:0]  i_cpu_rd_mask;
  logic [31:0] o_cpu_rd_data;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] i_mem_rd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  int checks   = 0;
  int failures = 0;

  mmio_console_bridge #(
    .CONSOLE_BASE(Base),
    .FIFO_DEPTH  (16)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_halt       (i_halt),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_wr_data(i_cpu_wr_data),
    .i_cpu_wr_mask(i_cpu_wr_mask),
    .i_cpu_rd_mask(i_cpu_rd_mask),
    .o_cpu_rd_data(o_cpu_rd_data),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_mask(o_mem_wr_mask),
    .o_mem_rd_mask(o_mem_rd_mask),
    .i_mem_rd_data(i_mem_rd_data),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One-cycle core write; strobe dropped right after the edge.
  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] mask);
    i_cpu_addr    = addr;
    i_cpu_wr_data = data;
    i_cpu_wr_mask = mask;
    step();
    i_cpu_wr_mask = 2'b00;
  endtask

  // Combinational window read between edges.
  task automatic rd_reg(input logic [1:0] sel, output logic [31:0] d);
    i_cpu_addr    = Base | {28'h0, sel, 2'b00};
    i_cpu_rd_mask = 3'b111;
    #1;
    d = o_cpu_rd_data;
    i_cpu_rd_mask = 3'b000;
  endtask

  logic [31:0] d;
  logic [7:0]  exp_b;

  initial begin
    i_reset       = 1'b1;
    i_halt        = 1'b0;
    i_cpu_addr    = 32'h0;
    i_cpu_wr_data = 32'h0;
    i_cpu_wr_mask = 2'b00;
    i_cpu_rd_mask = 3'b000;
    i_mem_rd_data = 32'h0;
    i_tx_ready    = 1'b0;
    step();
    step();
    i_reset = 1'b0;
    #1;

    // Reset state
    check("rst_valid", {31'h0, o_tx_valid}, 32'h0);
    check("rst_data", {24'h0, o_tx_data}, 32'h0);
    rd_reg(2'd1, d); check("rst_status", d, 32'h0000_0002);
    rd_reg(2'd2, d); check("rst_dropped", d, 32'h0);

    // Single byte push; in-window write suppressed toward Memory
    i_cpu_addr    = Base;
    i_cpu_wr_data = 32'h0000_0041;
    i_cpu_wr_mask = 2'b01;
    #1;
    check("win_wr_mask", {30'h0, o_mem_wr_mask}, 32'h0);
    check("pre_push_valid", {31'h0, o_tx_valid}, 32'h0);
    step();
    i_cpu_wr_mask = 2'b00;
    check("push1_valid", {31'h0, o_tx_valid}, 32'h1);
    check("push1_data", {24'h0, o_tx_data}, 32'h41);
    rd_reg(2'd1, d); check("push1_status", d, 32'h0000_0100);

    // Pop it
    i_tx_ready = 1'b1;
    step();
    i_tx_ready = 1'b0;
    check("pop1_valid", {31'h0, o_tx_valid}, 32'h0);
    check("pop1_data", {24'h0, o_tx_data}, 32'h0);
    rd_reg(2'd1, d); check("pop1_status", d, 32'h0000_0002);

    // Fill with 0x00..0x0F, mixed mask sizes, upper bytes non-zero
    for (int i = 0; i < 16; i++) begin
      cpu_write(Base, 32'hABCD_EF00 | 32'(i), (i % 3 == 0) ? 2'b11 : 2'b01);
    end
    rd_reg(2'd1, d); check("full_status", d, 32'h0000_1001);
    check("full_head", {24'h0, o_tx_data}, 32'h00);

    // 17th push dropped
    cpu_write(Base, 32'h0000_0055, 2'b10);
    rd_reg(2'd2, d); check("drop1", d, 32'h1);
    rd_reg(2'd1, d); check("drop_status", d, 32'h0000_1001);
    check("drop_head", {24'h0, o_tx_data}, 32'h00);

    // Push while full with a simultaneous pop
    i_tx_ready = 1'b1;
    cpu_write(Base, 32'h0000_00AA, 2'b01);
    rd_reg(2'd1, d); check("pushpop_status", d, 32'h0000_1001);
    rd_reg(2'd2, d); check("pushpop_dropped", d, 32'h1);

    // Drain: 0x01..0x0F then 0xAA
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 1) : 8'hAA;
      check($sformatf("drain%0d", i), {23'h0, o_tx_valid, o_tx_data}, {23'h0, 1'b1, exp_b});
      step();
    end
    i_tx_ready = 1'b0;
    check("drained_valid", {31'h0, o_tx_valid}, 32'h0);
    rd_reg(2'd1, d); check("drained_status", d, 32'h0000_0002);

    // Pass-through
    i_cpu_addr    = 32'h0000_1000;
    i_cpu_wr_data = 32'hDEAD_BEEF;
    i_cpu_wr_mask = 2'b11;
    i_cpu_rd_mask = 3'b010;
    i_mem_rd_data = 32'h1234_5678;
    #1;
    check("pt_addr", o_mem_addr, 32'h0000_1000);
    check("pt_wdata", o_mem_wr_data, 32'hDEAD_BEEF);
    check("pt_wmask", {30'h0, o_mem_wr_mask}, 32'h3);
    check("pt_rmask", {29'h0, o_mem_rd_mask}, 32'h2);
    check("pt_rdata", o_cpu_rd_data, 32'h1234_5678);
    step();
    i_cpu_wr_mask = 2'b00;
    i_cpu_rd_mask = 3'b000;
    rd_reg(2'd1, d); check("pt_no_push", d, 32'h0000_0002);
    i_cpu_rd_mask = 3'b100;
    i_cpu_addr    = Base | 32'h4;
    #1;
    check("win_rd_mask", {29'h0, o_mem_rd_mask}, 32'h0);
    i_cpu_rd_mask = 3'b000;
    rd_reg(2'd3, d); check("reserved_rd", d, 32'h0);

    // Word write to TXDATA pushes the low byte; write to DROPPED ignored
    cpu_write(Base, 32'h1234_5677, 2'b11);
    cpu_write(Base | 32'h8, 32'h0, 2'b11);
    rd_reg(2'd2, d); check("dropped_wr_ign", d, 32'h1);
    check("word_push", {24'h0, o_tx_data}, 32'h77);

    // Halt: write ignored, drain continues
    i_halt = 1'b1;
    cpu_write(Base, 32'h0000_0099, 2'b01);
    rd_reg(2'd1, d); check("halt_status", d, 32'h0000_0100);
    rd_reg(2'd2, d); check("halt_dropped", d, 32'h1);
    check("halt_head", {24'h0, o_tx_data}, 32'h77);
    i_tx_ready = 1'b1;
    step();
    check("halt_drain", {31'h0, o_tx_valid}, 32'h0);
    i_halt = 1'b0;

    // Push into empty FIFO while ready is high
    cpu_write(Base, 32'h0000_0066, 2'b01);
    check("empty_pushpop", {23'h0, o_tx_valid, o_tx_data}, 32'h0000_0166);
    step();
    i_tx_ready = 1'b0;
    check("empty_pushpop_gone", {31'h0, o_tx_valid}, 32'h0);

    // Asynchronous reset with 5 entries queued
    for (int i = 0; i < 5; i++) begin
      cpu_write(Base, 32'h10 + 32'(i), 2'b01);
    end
    rd_reg(2'd1, d); check("five_status", d, 32'h0000_0500);
    #2;
    i_reset = 1'b1;
    #1;
    check("arst_valid", {31'h0, o_tx_valid}, 32'h0);
    check("arst_data", {24'h0, o_tx_data}, 32'h0);
    step();
    i_reset = 1'b0;
    #1;
    rd_reg(2'd1, d); check("arst_status", d, 32'h0000_0002);
    rd_reg(2'd2, d); check("arst_dropped", d, 32'h0);
    cpu_write(Base, 32'h0000_0033, 2'b01);
    check("post_rst_push", {23'h0, o_tx_valid, o_tx_data}, 32'h0000_0133);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
